booth_div_iter: RTL and testbench

- Sequential signed integer divider: the inverse operation to the team's pipelined radix-4 Booth multiplier, sharing the same 8-bit two's-complement datapath width.
- Radix-2 non-restoring algorithm, one quotient bit per clock, with valid/ready handshakes on input and output.
- Truncating (C-style) semantics: quotient rounds toward zero; a non-zero remainder takes the dividend's sign.
- Sits beside the multiplier in the arithmetic block; its product-check path feeds dividend/divisor pairs back through it.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_nr_step.sv | 29 ++
 rtl/booth_div_iter.sv | 190 +++++++++++++++++++
 tb/tb_booth_div_iter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed divider: state encoding and
// width-derived constants used by the divider top and its step logic.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Width of the iteration counter for an operand width w (never below 1 bit).
    function automatic int div_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Cycles from the operand transfer edge to out_valid rising.
    function automatic int div_latency(input int w);
        return w + 2;
    endfunction

    localparam int DIV_CNT_W   = div_cnt_w(DIV_WIDTH);
    localparam int DIV_LATENCY = div_latency(DIV_WIDTH);

endpackage

// File: rtl/div_nr_step.sv
// One radix-2 non-restoring division step on magnitudes: shift {rem, quo}
// left, then subtract or add the divisor depending on the old remainder sign.
module div_nr_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_mag_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_ext;

    // The remainder always lies in [-D, D), so its top two bits agree and
    // dropping the sign bit during the shift loses nothing.
    always_comb begin
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        dvs_ext = {1'b0, dvs_mag_i};
        if (rem_i[WIDTH]) begin
            rem_o = shifted + dvs_ext;
        end else begin
            rem_o = shifted - dvs_ext;
        end
        quo_o = {quo_i[WIDTH-2:0], ~rem_o[WIDTH]};
    end

endmodule

// File: rtl/booth_div_iter.sv
// Sequential signed divider (truncating, C semantics), one quotient bit per
// clock, with valid/ready handshakes on operands and result.
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high; a valid side holds its payload stable until that edge.
module booth_div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic             overflow_o
);

    localparam int CNT_W = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             q_neg_q, q_neg_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] rem_mag;
    logic             in_fire;
    logic             out_fire;

    div_nr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .dvs_mag_i (dvs_mag_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign in_ready_o    = (state_q == ST_IDLE);
    assign out_valid_o   = out_valid_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = div_by_zero_q;
    assign overflow_o    = overflow_q;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_q && out_ready_i;

    // Final restoring correction: a negative partial remainder gets D added back.
    assign rem_mag = rem_q[WIDTH] ? (rem_q[WIDTH-1:0] + dvs_mag_q) : rem_q[WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        dvs_mag_d     = dvs_mag_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvd_neg_d     = dvd_neg_q;
        q_neg_d       = q_neg_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    dvd_d   = dividend_i;
                    dvs_d   = divisor_i;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                dvd_neg_d = dvd_q[WIDTH-1];
                q_neg_d   = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                // Negating the most-negative value yields 2^(WIDTH-1), which is
                // exactly representable as an unsigned WIDTH-bit magnitude.
                quo_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
                dvs_mag_d = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                dbz_d     = (dvs_q == '0);
                ovf_d     = (dvd_q == MIN_VAL) && (dvs_q == ALL_ONES);
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = ST_ITER;
            end
            ST_ITER: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (dbz_q) begin
                    quotient_d  = ALL_ONES;
                    remainder_d = dvd_q;
                end else if (ovf_q) begin
                    quotient_d  = MIN_VAL;
                    remainder_d = '0;
                end else begin
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = dvd_neg_q ? -rem_mag : rem_mag;
                end
                div_by_zero_d = dbz_q;
                overflow_d    = ovf_q && !dbz_q;
                out_valid_d   = 1'b1;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            dvs_mag_q     <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvd_neg_q     <= 1'b0;
            q_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            dvs_mag_q     <= dvs_mag_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvd_neg_q     <= dvd_neg_d;
            q_neg_q       <= q_neg_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_booth_div_iter.sv
// Directed and table-driven checks of the iterative signed divider: latency,
// sign handling, special cases, backpressure and mid-operation reset.
module tb_booth_div_iter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_div_iter #(
        .WIDTH (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero),
        .overflow_o    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the transfer edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, input bit chk_busy);
        lat = 0;
        do begin
            if (chk_busy) chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 40);
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic chk_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf);
        chk({tag, " q"}, 32'(quotient), 32'(q));
        chk({tag, " r"}, 32'(remainder), 32'(r));
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(dbz));
        chk({tag, " ovf"}, 32'(overflow), 32'(ovf));
    endtask

    task automatic release_out(input int bp);
        repeat (bp) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r,
                            input logic dbz, input logic ovf);
        int lat;
        start_op(a, b);
        wait_result(lat, 1'b1);
        chk({tag, " latency"}, 32'(lat), 32'd10);
        chk_result(tag, q, r, dbz, ovf);
        release_out(0);
        chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int a_list[$];
        int b_list[$];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk_result("rst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("100/7",   8'd100,  8'd7,    8'd14,   8'd2,   1'b0, 1'b0);
        directed("-100/7",  8'h9C,   8'd7,    8'hF2,   8'hFE,  1'b0, 1'b0);
        directed("100/-7",  8'd100,  8'hF9,   8'hF2,   8'd2,   1'b0, 1'b0);
        directed("-100/-7", 8'h9C,   8'hF9,   8'd14,   8'hFE,  1'b0, 1'b0);
        directed("7/100",   8'd7,    8'd100,  8'd0,    8'd7,   1'b0, 1'b0);
        directed("-128/-1", 8'h80,   8'hFF,   8'h80,   8'd0,   1'b0, 1'b1);
        directed("-128/1",  8'h80,   8'd1,    8'h80,   8'd0,   1'b0, 1'b0);
        directed("5/0",     8'd5,    8'd0,    8'hFF,   8'd5,   1'b1, 1'b0);
        directed("0/9",     8'd0,    8'd9,    8'd0,    8'd0,   1'b0, 1'b0);
        directed("127/-128",8'd127,  8'h80,   8'd0,    8'd127, 1'b0, 1'b0);

        // Backpressure: result held for 6 cycles while stray in_valid pulses arrive.
        start_op(8'd45, 8'd6);
        wait_result(lat, 1'b1);
        chk("bp latency", 32'(lat), 32'd10);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            dividend = 8'd99;
            divisor  = 8'd1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk_result("bp hold", 8'd7, 8'd3, 1'b0, 1'b0);
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        release_out(0);
        chk("bp idle", 32'(in_ready), 32'd1);
        directed("bp next -45/6", 8'hD3, 8'd6, 8'hF9, 8'hFD, 1'b0, 1'b0);

        // Reset in the middle of an iteration run.
        start_op(8'd50, 8'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk_result("midrst", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        directed("27/-4", 8'd27, 8'hFC, 8'hFA, 8'd3, 1'b0, 1'b0);

        // Table sweep against a truncating-division model with random backpressure.
        a_list = '{-128, -127, -100, -65, -64, -9, -1, 0, 1, 9, 63, 64, 100, 126, 127};
        b_list = '{-128, -127, -64, -7, -3, -2, -1, 0, 1, 2, 3, 5, 7, 10, 64, 126, 127};
        foreach (a_list[i]) begin
            foreach (b_list[j]) begin
                int a, b, q, r;
                logic dbz, ovf;
                a = a_list[i];
                b = b_list[j];
                dbz = 1'b0;
                ovf = 1'b0;
                if (b == 0) begin
                    q = -1;
                    r = a;
                    dbz = 1'b1;
                end else if (a == -128 && b == -1) begin
                    q = -128;
                    r = 0;
                    ovf = 1'b1;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                start_op(a[7:0], b[7:0]);
                wait_result(lat, 1'b0);
                chk_result($sformatf("sweep %0d/%0d", a, b), q[7:0], r[7:0], dbz, ovf);
                release_out($urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
